seven_segment_reader: RTL

- Inverse of the team's 7448-style seven-segment decoder.
- Monitors a multiplexed, scanned seven-segment display bus (segment lines plus one-hot digit strobes) and recovers the displayed digit codes.
- Qualifies each strobed pattern for stability and encodes it back to 4-bit BCD.
- Assembles a complete multi-digit frame and publishes it with a one-cycle valid pulse; used for display loopback checking and front-panel readback.

---
 rtl/seven_segment_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seven_segment_reader.sv
// Reads a scanned seven-segment bus back into BCD digits: each strobed pattern
// must hold steady before capture, and a full set of digits is published as one frame.
module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [6:0]              SEG,
  input  logic [NUM_DIGITS-1:0]   DIG,
  output logic [4*NUM_DIGITS-1:0] VALUE,
  output logic [NUM_DIGITS-1:0]   BLANK,
  output logic                    ERR,
  output logic                    VALID
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);
  localparam int PW = NUM_DIGITS + 7;

  logic [PW-1:0]           prev_q;
  logic [CW-1:0]           cnt_q, cnt_next;
  logic [NUM_DIGITS-1:0]   mask_q, mask_next;
  logic [4*NUM_DIGITS-1:0] shadow_value_q, shadow_value_next;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_next;
  logic                    shadow_err_q, shadow_err_next;
  logic [3:0]              nib;
  logic                    pat_blank, pat_bad;
  logic                    capture, complete;

  always_comb begin
    nib       = 4'hE;
    pat_blank = 1'b0;
    pat_bad   = 1'b0;
    case (SEG)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7C: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h67: nib = 4'h9;
      7'h00: begin
        nib       = 4'hF;
        pat_blank = 1'b1;
      end
      default: begin
        nib     = 4'hE;
        pat_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    if ({DIG, SEG} != prev_q)
      cnt_next = CW'(1);
    else if (cnt_q != STABLE)
      cnt_next = cnt_q + 1'b1;
    else
      cnt_next = cnt_q;

    // Capture only on the transition into saturation, so a held pattern is taken once.
    capture = EN && $onehot(DIG) && (cnt_next == STABLE) && (cnt_q != STABLE);

    shadow_value_next = shadow_value_q;
    shadow_blank_next = shadow_blank_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (DIG[i]) begin
        shadow_value_next[4*i +: 4] = nib;
        shadow_blank_next[i]        = pat_blank;
      end
    end
    mask_next       = mask_q | DIG;
    shadow_err_next = shadow_err_q | pat_bad;
    complete        = capture && (&mask_next);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q         <= '0;
      cnt_q          <= '0;
      mask_q         <= '0;
      shadow_value_q <= '0;
      shadow_blank_q <= '0;
      shadow_err_q   <= 1'b0;
      VALUE          <= '0;
      BLANK          <= '0;
      ERR            <= 1'b0;
      VALID          <= 1'b0;
    end else begin
      prev_q <= {DIG, SEG};
      VALID  <= 1'b0;
      if (!EN) begin
        cnt_q        <= '0;
        mask_q       <= '0;
        shadow_err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_next;
        if (capture) begin
          shadow_value_q <= shadow_value_next;
          shadow_blank_q <= shadow_blank_next;
          if (complete) begin
            VALUE        <= shadow_value_next;
            BLANK        <= shadow_blank_next;
            ERR          <= shadow_err_next;
            VALID        <= 1'b1;
            mask_q       <= '0;
            shadow_err_q <= 1'b0;
          end else begin
            mask_q       <= mask_next;
            shadow_err_q <= shadow_err_next;
          end
        end
      end
    end
  end

endmodule
